// File: rtl/reward_manager.sv
// rtl/reward_manager.sv - reward item spawn, lifetime and active-reward timer for the snake game
module reward_manager #(
    parameter int TICK_DIV    = 25_000_000,
    parameter int REWARD_SECS = 30,
    parameter int SPAWN_SECS  = 5,
    parameter int ITEM_SECS   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_run,
    input  logic       reward_hit,
    output logic       item_valid,
    output logic [5:0] item_x,
    output logic [4:0] item_y,
    output logic       enable_reward,
    output logic       reward_protected,
    output logic       reward_grade,
    output logic       reward_slowly,
    output logic [9:0] reward_cnt
);

    localparam int              TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [9:0]      SPAWN_LAST  = 10'(SPAWN_SECS - 1);
    localparam logic [9:0]      ITEM_LAST   = 10'(ITEM_SECS - 1);
    localparam logic [9:0]      REWARD_MAX  = 10'(REWARD_SECS);
    localparam logic [15:0]     LFSR_SEED   = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPAWN = 2'd1,
        ITEM       = 2'd2,
        ACTIVE     = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [9:0]    secs;
    logic [15:0]   lfsr;
    logic [1:0]    item_type;

    logic          tick;
    logic          lfsr_fb;
    logic [TW-1:0] tick_cnt_next;
    logic [9:0]    secs_next;

    assign tick          = (tick_cnt == TICK_LAST);
    assign tick_cnt_next = tick ? '0 : tick_cnt + 1'b1;
    assign secs_next     = (tick && (secs != 10'h3FF)) ? secs + 10'd1 : secs;

    // Taps 16,14,13,11; a nonzero seed can never reach the all-zero lockup state.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            tick_cnt         <= '0;
            secs             <= '0;
            lfsr             <= LFSR_SEED;
            item_type        <= 2'b00;
            item_valid       <= 1'b0;
            item_x           <= '0;
            item_y           <= '0;
            enable_reward    <= 1'b0;
            reward_protected <= 1'b0;
            reward_grade     <= 1'b0;
            reward_slowly    <= 1'b0;
            reward_cnt       <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};

            if (!game_run) begin
                state            <= IDLE;
                tick_cnt         <= '0;
                secs             <= '0;
                item_type        <= 2'b00;
                item_valid       <= 1'b0;
                item_x           <= '0;
                item_y           <= '0;
                enable_reward    <= 1'b0;
                reward_protected <= 1'b0;
                reward_grade     <= 1'b0;
                reward_slowly    <= 1'b0;
                reward_cnt       <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state         <= WAIT_SPAWN;
                        tick_cnt      <= '0;
                        secs          <= '0;
                        enable_reward <= 1'b1;
                    end

                    WAIT_SPAWN: begin
                        // Leave on the tick that completes the last second, not one cycle after.
                        if (tick && (secs == SPAWN_LAST)) begin
                            state      <= ITEM;
                            tick_cnt   <= '0;
                            secs       <= '0;
                            item_valid <= 1'b1;
                            item_x     <= {1'b0, lfsr[4:0]} + 6'd4;
                            item_y     <= {1'b0, lfsr[11:8]} + 5'd4;
                            item_type  <= lfsr[15:14];
                        end else begin
                            tick_cnt <= tick_cnt_next;
                            secs     <= secs_next;
                        end
                    end

                    ITEM: begin
                        if (reward_hit) begin
                            state            <= ACTIVE;
                            tick_cnt         <= '0;
                            secs             <= '0;
                            item_valid       <= 1'b0;
                            item_x           <= '0;
                            item_y           <= '0;
                            reward_protected <= (item_type == 2'b00);
                            reward_grade     <= item_type[0];
                            reward_slowly    <= (item_type == 2'b10);
                            reward_cnt       <= '0;
                        end else if (tick && (secs == ITEM_LAST)) begin
                            state      <= WAIT_SPAWN;
                            tick_cnt   <= '0;
                            secs       <= '0;
                            item_valid <= 1'b0;
                            item_x     <= '0;
                            item_y     <= '0;
                        end else begin
                            tick_cnt <= tick_cnt_next;
                            secs     <= secs_next;
                        end
                    end

                    ACTIVE: begin
                        // reward_cnt shows the final value for one cycle before the reward ends.
                        if (reward_cnt >= REWARD_MAX) begin
                            state            <= WAIT_SPAWN;
                            tick_cnt         <= '0;
                            secs             <= '0;
                            reward_protected <= 1'b0;
                            reward_grade     <= 1'b0;
                            reward_slowly    <= 1'b0;
                            reward_cnt       <= '0;
                        end else begin
                            tick_cnt   <= tick_cnt_next;
                            secs       <= secs_next;
                            reward_cnt <= (secs_next > REWARD_MAX) ? REWARD_MAX : secs_next;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reward_manager.sv
// tb/tb_reward_manager.sv - self-checking bench for reward_manager
module tb_reward_manager;

    localparam int TD = 4;
    localparam int SP = 2;
    localparam int IT = 3;
    localparam int RS = 5;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_ITEM = 2;
    localparam int P_ACT  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_run = 1'b0;
    logic       reward_hit = 1'b0;
    logic       item_valid;
    logic [5:0] item_x;
    logic [4:0] item_y;
    logic       enable_reward;
    logic       reward_protected;
    logic       reward_grade;
    logic       reward_slowly;
    logic [9:0] reward_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reward_manager #(
        .TICK_DIV   (TD),
        .REWARD_SECS(RS),
        .SPAWN_SECS (SP),
        .ITEM_SECS  (IT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .game_run        (game_run),
        .reward_hit      (reward_hit),
        .item_valid      (item_valid),
        .item_x          (item_x),
        .item_y          (item_y),
        .enable_reward   (enable_reward),
        .reward_protected(reward_protected),
        .reward_grade    (reward_grade),
        .reward_slowly   (reward_slowly),
        .reward_cnt      (reward_cnt)
    );

    // Reference model: phase plus cycles spent in that phase.
    int          ph;
    int          n;
    logic [15:0] m_lfsr;
    logic [5:0]  mx;
    logic [4:0]  my;
    logic [1:0]  mt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    task automatic model_reset();
        ph     = P_IDLE;
        n      = 0;
        m_lfsr = 16'hACE1;
        mx     = '0;
        my     = '0;
        mt     = '0;
    endtask

    task automatic model_step();
        logic [15:0] prev;
        if (!rst_n) begin
            model_reset();
        end else begin
            prev   = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            if (!game_run) begin
                ph = P_IDLE;
                n  = 0;
            end else begin
                case (ph)
                    P_IDLE: begin
                        ph = P_WAIT;
                        n  = 0;
                    end
                    P_WAIT: begin
                        n++;
                        if (n == SP * TD) begin
                            ph = P_ITEM;
                            n  = 0;
                            mx = 6'(int'(prev[4:0]) + 4);
                            my = 5'(int'(prev[11:8]) + 4);
                            mt = prev[15:14];
                        end
                    end
                    P_ITEM: begin
                        if (reward_hit) begin
                            ph = P_ACT;
                            n  = 0;
                        end else begin
                            n++;
                            if (n == IT * TD) begin
                                ph = P_WAIT;
                                n  = 0;
                            end
                        end
                    end
                    default: begin
                        n++;
                        if (n == RS * TD + 1) begin
                            ph = P_WAIT;
                            n  = 0;
                        end
                    end
                endcase
            end
        end
    endtask

    function automatic logic [25:0] model_vec();
        logic act;
        int   c;
        act = (ph == P_ACT);
        c   = act ? ((n / TD) > RS ? RS : (n / TD)) : 0;
        return {ph == P_ITEM, (ph == P_ITEM) ? mx : 6'd0, (ph == P_ITEM) ? my : 5'd0,
                ph != P_IDLE, act && (mt == 2'b00), act && mt[0], act && (mt == 2'b10), 10'(c)};
    endfunction

    function automatic logic [25:0] dut_vec();
        return {item_valid, item_x, item_y, enable_reward,
                reward_protected, reward_grade, reward_slowly, reward_cnt};
    endfunction

    task automatic tick_check();
        @(posedge clk);
        model_step();
        #1;
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL model t=%0t: got %h, expected %h", $time, dut_vec(), model_vec());
        end
    endtask

    typedef struct packed {
        logic       gr;
        logic       hit;
        logic [7:0] ncyc;
        logic       iv;
        logic       en;
        logic       flag;
        logic [9:0] cnt;
    } row_t;

    function automatic row_t mk(input logic gr, input logic hit, input int ncyc,
                                input logic iv, input logic en, input logic flag, input int cnt);
        row_t r;
        r.gr   = gr;
        r.hit  = hit;
        r.ncyc = 8'(ncyc);
        r.iv   = iv;
        r.en   = en;
        r.flag = flag;
        r.cnt  = 10'(cnt);
        return r;
    endfunction

    row_t tbl [19];

    initial begin
        int nflags;

        tbl[0]  = mk(0, 0,  1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0,  1, 0, 1, 0, 0);
        tbl[2]  = mk(1, 0,  7, 0, 1, 0, 0);
        tbl[3]  = mk(1, 0,  1, 1, 1, 0, 0);
        tbl[4]  = mk(1, 1,  1, 0, 1, 1, 0);
        tbl[5]  = mk(1, 0,  4, 0, 1, 1, 1);
        tbl[6]  = mk(1, 0, 16, 0, 1, 1, 5);
        tbl[7]  = mk(1, 0,  1, 0, 1, 0, 0);
        tbl[8]  = mk(1, 0,  8, 1, 1, 0, 0);
        tbl[9]  = mk(1, 0, 11, 1, 1, 0, 0);
        tbl[10] = mk(1, 0,  1, 0, 1, 0, 0);
        tbl[11] = mk(1, 0,  8, 1, 1, 0, 0);
        tbl[12] = mk(1, 0, 11, 1, 1, 0, 0);
        tbl[13] = mk(1, 1,  1, 0, 1, 1, 0);
        tbl[14] = mk(1, 0, 12, 0, 1, 1, 3);
        tbl[15] = mk(0, 0,  1, 0, 0, 0, 0);
        tbl[16] = mk(0, 1,  3, 0, 0, 0, 0);
        tbl[17] = mk(1, 1,  1, 0, 1, 0, 0);
        tbl[18] = mk(1, 1,  3, 0, 1, 0, 0);

        model_reset();
        repeat (3) tick_check();
        checks++;
        if (dut_vec() !== 26'd0) begin
            errors++;
            $display("FAIL reset_state: got %h, expected 0", dut_vec());
        end
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            game_run   = tbl[i].gr;
            reward_hit = tbl[i].hit;
            for (int k = 0; k < int'(tbl[i].ncyc); k++) tick_check();
            nflags = int'(reward_protected) + int'(reward_grade) + int'(reward_slowly);
            checks++;
            if (item_valid !== tbl[i].iv || enable_reward !== tbl[i].en ||
                nflags != int'(tbl[i].flag) || reward_cnt !== tbl[i].cnt) begin
                errors++;
                $display("FAIL row%0d: got iv=%b en=%b flags=%0d cnt=%0d, expected iv=%b en=%b flags=%0d cnt=%0d",
                         i, item_valid, enable_reward, nflags, reward_cnt,
                         tbl[i].iv, tbl[i].en, tbl[i].flag, tbl[i].cnt);
            end
            if (tbl[i].iv) begin
                checks++;
                if (item_x < 6'd4 || item_x > 6'd35 || item_y < 5'd4 || item_y > 5'd19) begin
                    errors++;
                    $display("FAIL row%0d_range: got x=%0d y=%0d, expected x 4..35 y 4..19", i, item_x, item_y);
                end
            end
        end

        reward_hit = 1'b0;
        for (int i = 0; i < 20 && ph != P_ITEM; i++) tick_check();
        tick_check();
        tick_check();
        checks++;
        if (item_valid !== 1'b1) begin
            errors++;
            $display("FAIL reach_item: got item_valid=%b, expected 1", item_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 26'd0) begin
            errors++;
            $display("FAIL async_reset: got %h, expected 0", dut_vec());
        end
        model_reset();
        #1;
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            game_run   = ($urandom_range(0, 299) != 0);
            reward_hit = ($urandom_range(0, 7) == 0);
            tick_check();
            checks++;
            if ((int'(reward_protected) + int'(reward_grade) + int'(reward_slowly)) > 1 ||
                reward_cnt > 10'(RS)) begin
                errors++;
                $display("FAIL invariant: got flags=%b%b%b cnt=%0d, expected <=1 flag and cnt<=%0d",
                         reward_protected, reward_grade, reward_slowly, reward_cnt, RS);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
